// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and data access.
// Data side wins ties; a saturating counter forces fetch through after a run of data grants.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  input  logic [1:0]        dm_op,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ready,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;

  logic dm_valid;
  logic dm_we;
  logic if_pend;
  logic dm_pend;
  logic grant_i;
  logic grant_d;
  logic done_i;
  logic done_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (grant_d)      state_nxt = SERVE_D;
        else if (grant_i) state_nxt = SERVE_I;
      end
      SERVE_I,
      SERVE_D: begin
        if (mem_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A port whose ready pulse is high is not re-sampled this cycle.
  always_comb begin
    dm_we    = (dm_op == 2'b10);
    dm_valid = (dm_op == 2'b01) || dm_we;
    if_pend  = if_req & ~if_ready;
    dm_pend  = dm_valid & ~dm_ready;
    grant_d  = 1'b0;
    grant_i  = 1'b0;
    done_i   = 1'b0;
    done_d   = 1'b0;
    unique case (state)
      IDLE: begin
        grant_d = dm_pend & ~(if_pend & (cnt == LIMIT));
        grant_i = if_pend & ~grant_d;
      end
      SERVE_I: done_i = mem_ack;
      SERVE_D: done_d = mem_ack;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      if_ready  <= 1'b0;
      dm_ready  <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      cnt       <= '0;
    end else begin
      if_ready <= done_i;
      dm_ready <= done_d;
      if (grant_d) begin
        mem_req   <= 1'b1;
        busy      <= 1'b1;
        mem_we    <= dm_we;
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
      end else if (grant_i) begin
        mem_req   <= 1'b1;
        busy      <= 1'b1;
        mem_we    <= 1'b0;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
      end
      if (done_i || done_d) begin
        mem_req <= 1'b0;
        busy    <= 1'b0;
      end
      if (done_i) if_rdata <= mem_rdata;
      if (done_d && !mem_we) dm_rdata <= mem_rdata;
      if (grant_i)
        cnt <= '0;
      else if (grant_d && if_pend && cnt != LIMIT)
        cnt <= cnt + 4'd1;
    end
  end

endmodule
